// File: rtl/ber_pkg.sv
// Shared types and constants for the BER checker slice.
package ber_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COUNT  = 2'd2
  } state_t;

  localparam int CNT_W = 64;
  localparam int LAT_W = 9;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/ber_checker_slicer_decim.sv
// Decimator and BPSK slicer: tracks the sample position within a baud and
// flags the decision sample selected by i_phase.
module ber_slicer_decim
  import ber_pkg::*;
#(
  parameter int NB_INPUT = 8,
  parameter int OS       = 4
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic                       i_valid,
  input  logic [1:0]                 i_phase,
  output logic                       o_rx_bit,
  output logic                       o_dec
);

  logic [1:0] scnt;
  logic       unused_lsbs;

  // Sample counter within the baud, wrapping at OS-1.
  always_ff @(posedge clock) begin
    if (i_reset || i_clear) begin
      scnt <= '0;
    end else if (i_valid) begin
      scnt <= (scnt == 2'(OS - 1)) ? '0 : scnt + 2'd1;
    end
  end

  assign o_dec       = i_valid && (scnt == i_phase);
  assign o_rx_bit    = i_data[NB_INPUT-1];
  assign unused_lsbs = ^i_data[NB_INPUT-2:0];

endmodule

// File: rtl/ber_checker.sv
// BER checker top: latency search against the PRBS9 reference, then bit and
// error counting while locked. Optional macro BER_RESYNC_EN adds a windowed
// error monitor in COUNT that sends the block back to SEARCH.
module ber_checker
  import ber_pkg::*;
#(
  parameter int NB_INPUT   = 8,
  parameter int OS         = 4,
  parameter int MAX_LAT    = 511,
  parameter int SYNC_WIN   = 511,
  parameter int RESYNC_THR = 64
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic                       i_valid,
  input  logic                       i_ref_bit,
  input  logic                       i_enable,
  input  logic [1:0]                 i_phase,
  output logic [CNT_W-1:0]           o_error_count,
  output logic [CNT_W-1:0]           o_bit_count,
  output logic [LAT_W-1:0]           o_latency,
  output logic                       o_locked,
  output logic                       o_ber_zero
);

  // Window accumulators are sized for either a full window or the threshold.
  localparam int WIN_MAX = (SYNC_WIN > RESYNC_THR) ? SYNC_WIN : RESYNC_THR;
  localparam int WIN_W   = $clog2(WIN_MAX + 2);
  localparam int REF_W   = 2 ** LAT_W;

  state_t             state, next_state;
  logic               rx_bit, dec, dec_en;
  logic [MAX_LAT-1:0] ref_hist;
  logic [REF_W-1:0]   refv;
  logic [LAT_W-1:0]   lat_try, min_lat, lock_lat;
  logic [WIN_W-1:0]   dec_cnt, err_acc, min_err, win_total;
  logic               search_err, count_err;
  logic               win_last, last_cand, lock_now, enter_search;
  logic [CNT_W-1:0]   bit_nxt, err_nxt;
`ifdef BER_RESYNC_EN
  logic [WIN_W-1:0]   win_err, werr_total;
`endif

  ber_slicer_decim #(
    .NB_INPUT(NB_INPUT),
    .OS      (OS)
  ) u_slicer (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (!i_enable),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_phase (i_phase),
    .o_rx_bit(rx_bit),
    .o_dec   (dec)
  );

  assign dec_en = dec && i_enable;

  // Reference vector zero-padded to the full latency range so any index is legal.
  always_comb begin
    refv              = '0;
    refv[MAX_LAT:0]   = {ref_hist, i_ref_bit};
  end

  assign search_err = rx_bit ^ refv[lat_try];
  assign count_err  = rx_bit ^ refv[o_latency];
  assign win_total  = err_acc + WIN_W'(search_err);
  assign win_last   = (dec_cnt == WIN_W'(SYNC_WIN - 1));
  assign last_cand  = (lat_try == LAT_W'(MAX_LAT - 1));
  assign lock_lat   = ((win_total == '0) || (win_total < min_err)) ? lat_try : min_lat;
`ifdef BER_RESYNC_EN
  assign werr_total = win_err + WIN_W'(count_err);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and lock decision.
  always_comb begin
    next_state = state;
    lock_now   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) next_state = SEARCH;
      end
      SEARCH: begin
        if (!i_enable) begin
          next_state = IDLE;
        end else if (dec_en && win_last && ((win_total == '0) || last_cand)) begin
          lock_now   = 1'b1;
          next_state = COUNT;
        end
      end
      COUNT: begin
        if (!i_enable) begin
          next_state = IDLE;
`ifdef BER_RESYNC_EN
        end else if (dec_en && (werr_total >= WIN_W'(RESYNC_THR))) begin
          next_state = SEARCH;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
    enter_search = (next_state == SEARCH) && (state != SEARCH);
  end

  // Next values of the result counters; cleared on every entry into SEARCH.
  always_comb begin
    bit_nxt = o_bit_count;
    err_nxt = o_error_count;
    if (enter_search) begin
      bit_nxt = '0;
      err_nxt = '0;
    end else if ((state == COUNT) && dec_en) begin
      bit_nxt = sat_inc(o_bit_count, 1'b1);
      err_nxt = sat_inc(o_error_count, count_err);
    end
  end

  // Reference history, latency sweep and window bookkeeping.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      ref_hist  <= '0;
      lat_try   <= '0;
      min_lat   <= '0;
      dec_cnt   <= '0;
      err_acc   <= '0;
      min_err   <= '1;
      o_latency <= '0;
`ifdef BER_RESYNC_EN
      win_err   <= '0;
`endif
    end else begin
      if (dec_en) ref_hist <= {ref_hist[MAX_LAT-2:0], i_ref_bit};
      if (enter_search) begin
        lat_try <= '0;
        min_lat <= '0;
        dec_cnt <= '0;
        err_acc <= '0;
        min_err <= '1;
`ifdef BER_RESYNC_EN
        win_err <= '0;
`endif
      end else if ((state == SEARCH) && dec_en) begin
        if (win_last) begin
          dec_cnt <= '0;
          err_acc <= '0;
          if (win_total < min_err) begin
            min_err <= win_total;
            min_lat <= lat_try;
          end
          if (lock_now) begin
            o_latency <= lock_lat;
`ifdef BER_RESYNC_EN
            win_err   <= '0;
`endif
          end else begin
            lat_try <= lat_try + LAT_W'(1);
          end
        end else begin
          dec_cnt <= dec_cnt + WIN_W'(1);
          err_acc <= win_total;
        end
`ifdef BER_RESYNC_EN
      end else if ((state == COUNT) && dec_en) begin
        if (win_last) begin
          dec_cnt <= '0;
          win_err <= '0;
        end else begin
          dec_cnt <= dec_cnt + WIN_W'(1);
          win_err <= werr_total;
        end
`endif
      end
    end
  end

  // Registered result outputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_bit_count   <= '0;
      o_error_count <= '0;
      o_locked      <= 1'b0;
      o_ber_zero    <= 1'b0;
    end else begin
      o_bit_count   <= bit_nxt;
      o_error_count <= err_nxt;
      o_locked      <= (next_state == COUNT);
      o_ber_zero    <= (next_state == COUNT) && (err_nxt == '0);
    end
  end

endmodule

// File: doc/ber_checker.md
# ber_checker

Receive-side bit-error-rate checker that consumes the signed sample stream from the RC transmit filter. It decimates by the oversampling factor at a selectable phase and slices BPSK symbols to bits. It aligns the sliced bits against the local PRBS9 reference by sweeping candidate latencies, then counts received bits and bit errors once locked. It sits directly downstream of the filter and drives the BER/lock indicators in `top`.

## Interface
- `NB_INPUT`, 8, width of signed filter sample
- `OS`, 4, oversampling factor (samples per baud)
- `MAX_LAT`, 511, number of candidate latencies; also reference history depth
- `SYNC_WIN`, 511, decisions accumulated per latency candidate
- `RESYNC_THR`, 64, error threshold per window that triggers resync (used only with macro)
- `clock` in 1, system clock
- `i_reset` in 1, synchronous, active-high reset
- `i_data` in NB_INPUT, signed filter output sample
- `i_valid` in 1, sample strobe; one pulse per filter output
- `i_ref_bit` in 1, local PRBS9 reference bit, sampled on decision cycles
- `i_enable` in 1, RX enable (switch `i_sw[1]`)
- `i_phase` in 2, sample offset within baud, 0..OS-1
- `o_error_count` out 64, accumulated bit errors since lock
- `o_bit_count` out 64, accumulated compared bits since lock
- `o_latency` out 9, locked latency in bauds
- `o_locked` out 1, high in COUNT state
- `o_ber_zero` out 1, `o_locked && o_error_count==0`

## Operation
- Sample counter `scnt` counts 0..OS-1 on each `i_valid`, wraps at OS-1. A decision cycle is a cycle with `i_valid && scnt==i_phase`.
- Slicer: `rx_bit = i_data[NB_INPUT-1]`, so a negative sample gives 1.
- Reference vector `{ref_hist, i_ref_bit}`. Index L=0 is the current `i_ref_bit`; index L is the bit from L decisions earlier. On every decision, `i_ref_bit` is shifted into `ref_hist`. `ref_hist` fills during IDLE too while `i_enable` is high.
- States:
  - **IDLE**: entered on reset, or whenever `i_enable`=0 from any state.
    - `scnt` is cleared and counters hold.
    - When `i_enable` goes high, the block moves to SEARCH.
  - **SEARCH**: entered with counters, `lat_try`, and `err_acc` cleared, and `min_err` set to all-ones.
    - Each decision adds `rx_bit ^ ref[lat_try]` to `err_acc`.
    - After SYNC_WIN decisions, the window closes and its total includes the final decision. At window close:
      - If total is 0: lock immediately at `lat_try`.
      - Otherwise, if total is strictly less than `min_err`: update `min_err` and `min_lat`. Ties keep the lowest latency.
      - Then increment `lat_try` and clear `err_acc`.
    - After candidate MAX_LAT-1 closes, lock at `min_lat`.
  - **COUNT**: each decision increments `o_bit_count` and adds `rx_bit ^ ref[o_latency]` to `o_error_count`. Both counters saturate at 2^64-1.
- A change on `i_phase` takes effect at the next decision and does not resync.
- `i_reset` has priority over all other inputs.

## Timing
- Reset values:
  - all counters 0
  - `o_latency`=0, `o_locked`=0, `o_ber_zero`=0
  - state IDLE, `ref_hist`=0
- All outputs are registered. Counters reflect a decision one cycle after the decision cycle.
- `o_locked` rises on the cycle after the lock decision. `o_latency` is valid from the same cycle.
- Worst-case lock time is MAX_LAT·SYNC_WIN decisions. Best case is SYNC_WIN decisions at latency 0.
- `i_enable` falling mid-COUNT: the next cycle shows `o_locked`=0 and counters holding their values. Re-enable clears the counters on SEARCH entry.
- `i_valid` low causes no state change.

## Configuration
- `BER_RESYNC_EN` defined:
  - COUNT also runs a SYNC_WIN-decision window error counter.
  - If window errors reach RESYNC_THR, the block returns to SEARCH. Counters clear and `o_locked` drops the next cycle.
- Undefined: lock persists until reset or `i_enable` deasserts; there is no window counter logic.

## Structure
- Shared package `ber_pkg`:
  - state enum (IDLE, SEARCH, COUNT)
  - counter width constant (64)
  - latency width constant (9)
- One natural sub-module, `ber_slicer_decim`. It holds `scnt`, performs phase selection, and outputs `rx_bit` plus a decision strobe.

## Test plan
- **Reset:** hold `i_reset` 3 cycles with stimulus active. Expect all outputs 0 and IDLE.
- **Clean lock:**
  - Stimulus: OS=4, `i_valid` every cycle, `i_phase`=0, `i_data`=+64/−64 built from the reference delayed 5 bauds, `i_enable`=1.
  - Expect `o_locked`=1 and `o_latency`=5.
  - After 1000 further decisions, expect `o_bit_count`=1000, `o_error_count`=0, `o_ber_zero`=1.
- **Single error:** after lock, invert one phase-0 sample. Expect `o_error_count`=1 one cycle after that decision, and `o_ber_zero`=0.
- **Phase select:** valid symbol only at sample 2 of each baud, −1/0 noise elsewhere, `i_phase`=2. Expect lock and 0 errors. With `i_phase`=0, expect no zero-error lock and an error count of roughly 50% of bits.
- **Enable toggle:** drop `i_enable` after 200 counted bits. Expect `o_locked`=0 and counts held at 200. Reassert; expect counters 0 and a fresh lock.
- **Resync (BER_RESYNC_EN):** change the injected delay from 5 to 9 while locked. Expect resync and relock at `o_latency`=9. Without the macro, expect `o_locked` to stay 1 and errors to grow at about 0.5 per bit.
